// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: run-time divider, CPOL/CPHA, per-transfer bit count,
// registered sample/shift strobes and a go/tip/done handshake with abort.
module spi_sclk_engine #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 7
) (
    input  logic             wb_clk_in,
    input  logic             wb_rst_n,
    input  logic             go,
    input  logic             stop,
    input  logic [DIV_W-1:0] divider,
    input  logic [CNT_W-1:0] char_len,
    input  logic             cpol,
    input  logic             cpha,
    output logic             sclk_out,
    output logic             sample_stb,
    output logic             shift_stb,
    output logic             last_clk,
    output logic             tip,
    output logic             done
);

    // Edge counter holds 2*N; N can reach 2**CNT_W, so it needs CNT_W+2 bits.
    localparam int EW = CNT_W + 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] hcnt_q;
    logic [DIV_W-1:0] div_q;
    logic [EW-1:0]    edges_q;
    logic             cpol_q;
    logic             cpha_q;

    logic             start;
    logic             toggle;
    logic             finish;
    logic             abort;
    logic             leading;
    logic [CNT_W:0]   n_cyc;
    logic [EW-1:0]    edges_init;

    assign n_cyc      = (char_len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, char_len};
    assign edges_init = {n_cyc, 1'b0};
    // An even count of remaining edges means the next edge is a leading one.
    assign leading    = ~edges_q[0];
    assign last_clk   = tip & (edges_q <= EW'(2));

    // Handshake: go is accepted only in IDLE without stop; tip stays high for the
    // whole transfer and done pulses for one cycle as tip falls (completion or abort).
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        toggle  = 1'b0;
        finish  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (go && !stop) begin
                    start   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                toggle = (hcnt_q == div_q);
                if (toggle && edges_q == EW'(1)) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else if (stop) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q    <= IDLE;
            hcnt_q     <= '0;
            div_q      <= '0;
            edges_q    <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            sclk_out   <= 1'b0;
            sample_stb <= 1'b0;
            shift_stb  <= 1'b0;
            tip        <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sample_stb <= 1'b0;
            shift_stb  <= 1'b0;
            done       <= 1'b0;
            if (state_q == IDLE) begin
                sclk_out <= cpol;
                if (start) begin
                    div_q   <= divider;
                    cpol_q  <= cpol;
                    cpha_q  <= cpha;
                    hcnt_q  <= '0;
                    edges_q <= edges_init;
                    tip     <= 1'b1;
                end
            end else if (abort) begin
                sclk_out <= cpol_q;
                hcnt_q   <= '0;
                edges_q  <= '0;
                tip      <= 1'b0;
                done     <= 1'b1;
            end else if (toggle) begin
                hcnt_q   <= '0;
                sclk_out <= ~sclk_out;
                edges_q  <= edges_q - EW'(1);
                if (cpha_q) begin
                    shift_stb  <= leading;
                    sample_stb <= ~leading;
                end else begin
                    sample_stb <= leading;
                    shift_stb  <= ~leading && (edges_q != EW'(1));
                end
                if (finish) begin
                    sclk_out <= cpol_q;
                    tip      <= 1'b0;
                    done     <= 1'b1;
                end
            end else begin
                hcnt_q <= hcnt_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Randomized bench for spi_sclk_engine; expected outputs come from an
// arithmetic per-cycle model of the transfer timeline.
module tb_spi_sclk_engine;

    logic       wb_clk_in;
    logic       wb_rst_n;
    logic       go;
    logic       stop;
    logic [7:0] divider;
    logic [6:0] char_len;
    logic       cpol;
    logic       cpha;
    logic       sclk_out;
    logic       sample_stb;
    logic       shift_stb;
    logic       last_clk;
    logic       tip;
    logic       done;

    int n_checks;
    int n_fail;
    int obs_samples;
    int obs_dones;
    int obs_edges;

    spi_sclk_engine #(.DIV_W(8), .CNT_W(7)) dut (
        .wb_clk_in (wb_clk_in),
        .wb_rst_n  (wb_rst_n),
        .go        (go),
        .stop      (stop),
        .divider   (divider),
        .char_len  (char_len),
        .cpol      (cpol),
        .cpha      (cpha),
        .sclk_out  (sclk_out),
        .sample_stb(sample_stb),
        .shift_stb (shift_stb),
        .last_clk  (last_clk),
        .tip       (tip),
        .done      (done)
    );

    initial wb_clk_in = 1'b0;
    always #5 wb_clk_in = ~wb_clk_in;

    // One transfer: go is driven at the current negedge; stop_at (0 = none) is the
    // clock index after go at which stop is sampled; noise wiggles go and config.
    task automatic run_xfer(input string name, input int d, input int len, input bit pol,
                            input bit pha, input int stop_at, input bit noise);
        int h, n, e_tot, t_end, last_t, e;
        bit aborted, lead, prev_sclk;
        logic [5:0] exp_v, act_v;
        h = d + 1;
        n = (len == 0) ? 128 : len;
        e_tot = 2 * n;
        t_end = e_tot * h;
        aborted = (stop_at != 0) && (stop_at < t_end);
        last_t = aborted ? stop_at : t_end;
        obs_samples = 0;
        obs_dones = 0;
        obs_edges = 0;
        divider = 8'(d);
        char_len = 7'(len);
        cpol = pol;
        cpha = pha;
        stop = 1'b0;
        go = 1'b1;
        prev_sclk = pol;
        @(negedge wb_clk_in);
        for (int t = 0; t <= last_t; t++) begin
            if (aborted && t == stop_at) begin
                exp_v = {pol, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            end else begin
                e = t / h;
                exp_v = '0;
                exp_v[5] = pol ^ e[0];
                exp_v[1] = (t < t_end);
                exp_v[0] = (t == t_end);
                if (t > 0 && (t % h) == 0) begin
                    lead = (e % 2) == 1;
                    if (!pha) begin
                        exp_v[4] = lead;
                        exp_v[3] = !lead && (e != e_tot);
                    end else begin
                        exp_v[3] = lead;
                        exp_v[4] = !lead;
                    end
                end
                exp_v[2] = exp_v[1] && (e_tot - e <= 2);
            end
            act_v = {sclk_out, sample_stb, shift_stb, last_clk, tip, done};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d {sclk,smp,shf,last,tip,done} got %b expected %b",
                         name, t, act_v, exp_v);
            end
            obs_samples += int'(sample_stb);
            obs_dones += int'(done);
            if (sclk_out !== prev_sclk) obs_edges++;
            prev_sclk = sclk_out;
            go = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            stop = (t + 1 == stop_at);
            if (noise) begin
                divider = 8'($urandom);
                char_len = 7'($urandom);
                cpha = 1'($urandom_range(0, 1));
            end
            if (t == last_t) begin
                go = 1'b0;
                stop = 1'b0;
                cpol = pol;
            end
            @(negedge wb_clk_in);
        end
        n_checks++;
        if (tip !== 1'b0 || done !== 1'b0 || sclk_out !== pol) begin
            n_fail++;
            $display("FAIL %s idle_after tip=%b done=%b sclk=%b expected 0 0 %b",
                     name, tip, done, sclk_out, pol);
        end
    endtask

    task automatic test_reset();
        wb_rst_n = 1'b0;
        go = 1'b0;
        stop = 1'b0;
        divider = '0;
        char_len = '0;
        cpol = 1'b1;
        cpha = 1'b0;
        #1;
        n_checks++;
        if ({sclk_out, sample_stb, shift_stb, last_clk, tip, done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b expected 000000",
                     {sclk_out, sample_stb, shift_stb, last_clk, tip, done});
        end
        repeat (3) @(negedge wb_clk_in);
        n_checks++;
        if (sclk_out !== 1'b0 || tip !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held sclk=%b tip=%b expected 0 0", sclk_out, tip);
        end
        wb_rst_n = 1'b1;
        @(negedge wb_clk_in);
        n_checks++;
        if (sclk_out !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_follows_cpol1 got %b expected 1", sclk_out);
        end
        cpol = 1'b0;
        @(negedge wb_clk_in);
        n_checks++;
        if (sclk_out !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_follows_cpol0 got %b expected 0", sclk_out);
        end
    endtask

    task automatic test_go_with_stop();
        divider = 8'd0;
        char_len = 7'd1;
        go = 1'b1;
        stop = 1'b1;
        @(negedge wb_clk_in);
        go = 1'b0;
        stop = 1'b0;
        repeat (2) begin
            n_checks++;
            if (tip !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL go_and_stop tip=%b done=%b expected 0 0", tip, done);
            end
            @(negedge wb_clk_in);
        end
    endtask

    task automatic test_basic_modes();
        run_xfer("div1_len2_mode0", 1, 2, 1'b0, 1'b0, 0, 1'b0);
        run_xfer("div0_len3_mode3", 0, 3, 1'b1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_full_length();
        run_xfer("len0_256_edges", 0, 0, 1'b0, 1'b0, 0, 1'b0);
        n_checks++;
        if (obs_samples != 128 || obs_dones != 1 || obs_edges != 256) begin
            n_fail++;
            $display("FAIL len0_counts samples=%0d dones=%0d edges=%0d expected 128 1 256",
                     obs_samples, obs_dones, obs_edges);
        end
    endtask

    task automatic test_abort();
        run_xfer("stop_after_edge3", 3, 8, 1'b1, 1'b0, 13, 1'b1);
        n_checks++;
        if (obs_dones != 1) begin
            n_fail++;
            $display("FAIL abort_single_done got %0d expected 1", obs_dones);
        end
        // stop on the final-edge cycle completes normally with one done
        run_xfer("stop_on_final_edge", 1, 2, 1'b0, 1'b1, 8, 1'b0);
        n_checks++;
        if (obs_dones != 1) begin
            n_fail++;
            $display("FAIL final_stop_single_done got %0d expected 1", obs_dones);
        end
    endtask

    task automatic test_reset_mid_transfer();
        divider = 8'd3;
        char_len = 7'd4;
        cpol = 1'b1;
        cpha = 1'b0;
        go = 1'b1;
        @(negedge wb_clk_in);
        go = 1'b0;
        repeat (6) @(negedge wb_clk_in);
        #2;
        wb_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sclk_out, sample_stb, shift_stb, last_clk, tip, done} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset_mid got %b expected 000000",
                     {sclk_out, sample_stb, shift_stb, last_clk, tip, done});
        end
        @(negedge wb_clk_in);
        wb_rst_n = 1'b1;
        cpol = 1'b0;
        @(negedge wb_clk_in);
        run_xfer("after_reset_div2_len1", 2, 1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_max_divider();
        run_xfer("div255_noise", 255, 1, 1'b1, 1'b1, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            int d, len, s;
            d = $urandom_range(0, 5);
            len = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : $urandom_range(1, 6);
            s = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * len * (d + 1)) : 0;
            run_xfer($sformatf("rand%0d", i), d, len, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        run_xfer("b2b_first", 0, 1, 1'b0, 1'b0, 0, 1'b0);
        run_xfer("b2b_second", 2, 2, 1'b1, 1'b0, 0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_go_with_stop();
        test_basic_modes();
        test_full_length();
        test_abort();
        test_reset_mid_transfer();
        test_max_divider();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
